// File: rtl/pipelined_mem_responder.sv
// Main-memory responder behind the cache fill engine: single-cycle writes,
// fixed-latency pipelined reads with one response strobe per read.
module pipelined_mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              busy
);

    localparam int WORDS = 1 << (ADDR_W - 1);

    // Array is never touched by rst; the declaration value gives the power-up zero.
    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

    logic [ADDR_W-2:0] word_idx;
    logic              rd_req;
    logic              wr_req;

    logic              stg_valid [LATENCY];
    logic [DATA_W-1:0] stg_data  [LATENCY];
    logic [ADDR_W-1:0] stg_addr  [LATENCY];

    assign word_idx = addr[ADDR_W-1:1];
    assign rd_req   = enable & ~wr;
    assign wr_req   = enable & wr & ~rst;

    always_ff @(posedge clk) begin
        if (wr_req) begin
            mem[word_idx] <= data_in;
        end
    end

    // Idle slots carry zeros so the output stage never shows stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_valid[i] <= 1'b0;
                stg_data[i]  <= '0;
                stg_addr[i]  <= '0;
            end
        end else begin
            stg_valid[0] <= rd_req;
            stg_data[0]  <= rd_req ? mem[word_idx] : '0;
            stg_addr[0]  <= rd_req ? {word_idx, 1'b0} : '0;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_data[i]  <= stg_data[i-1];
                stg_addr[i]  <= stg_addr[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | stg_valid[i];
        end
    end

    assign data_valid = stg_valid[LATENCY-1];
    assign data_out   = stg_data[LATENCY-1];
    assign resp_addr  = stg_addr[LATENCY-1];

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Directed bench for pipelined_mem_responder: a LATENCY=4 instance for the
// main scenarios and a LATENCY=1 instance for the single-stage build.
module tb_pipelined_mem_responder;

    logic        clk;
    logic        rst, en, wr;
    logic [15:0] addr, din, dout, raddr;
    logic        dv, busy;

    logic        rst1, en1, wr1;
    logic [15:0] addr1, din1, dout1, raddr1;
    logic        dv1, busy1;

    int n_pass  = 0;
    int n_total = 0;

    pipelined_mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en), .wr(wr), .addr(addr), .data_in(din),
        .data_out(dout), .data_valid(dv), .resp_addr(raddr), .busy(busy)
    );

    pipelined_mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .enable(en1), .wr(wr1), .addr(addr1), .data_in(din1),
        .data_out(dout1), .data_valid(dv1), .resp_addr(raddr1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        en = 1'b1; wr = 1'b1; addr = a; din = d;
        cycle();
        en = 1'b0; wr = 1'b0;
    endtask

    // Issues one read and waits (bounded) for its response; lat counts
    // samples after the issue sample, -1 if none arrived.
    task automatic do_read(input logic [15:0] a, output logic [15:0] d,
                           output logic [15:0] ra, output int lat);
        en = 1'b1; wr = 1'b0; addr = a;
        cycle();
        en = 1'b0;
        lat = -1; d = '0; ra = '0;
        for (int k = 0; k < 12; k++) begin
            if (dv) begin
                lat = k; d = dout; ra = raddr;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        cycle();
        cycle();
        n_total++; if ({dv, busy} !== 2'b00) $display("FAIL reset_dv_busy: got %b want 00", {dv, busy}); else n_pass++;
        n_total++; if (dout !== 16'h0) $display("FAIL reset_data_out: got %h want 0000", dout); else n_pass++;
        n_total++; if (raddr !== 16'h0) $display("FAIL reset_resp_addr: got %h want 0000", raddr); else n_pass++;
        n_total++; if ({dv1, busy1} !== 2'b00) $display("FAIL reset_lat1_dv_busy: got %b want 00", {dv1, busy1}); else n_pass++;
        rst = 1'b0; rst1 = 1'b0;
        cycle();
    endtask

    task automatic test_write_read_latency();
        int busy_cnt;
        do_write(16'h0010, 16'h1234);
        en = 1'b1; wr = 1'b0; addr = 16'h0010;
        cycle();
        en = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy) busy_cnt++;
            if (k < 3) begin
                n_total++; if (dv !== 1'b0) $display("FAIL wr_rd_early_valid k=%0d: got %b want 0", k, dv); else n_pass++;
            end else if (k == 3) begin
                n_total++; if (dv !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", dv); else n_pass++;
                n_total++; if (dout !== 16'h1234) $display("FAIL wr_rd_data: got %h want 1234", dout); else n_pass++;
                n_total++; if (raddr !== 16'h0010) $display("FAIL wr_rd_addr: got %h want 0010", raddr); else n_pass++;
            end else if (k == 4) begin
                n_total++; if ({dv, dout, raddr} !== 33'h0) $display("FAIL wr_rd_idle_zero: got dv=%b data=%h addr=%h want 0", dv, dout, raddr); else n_pass++;
            end
            cycle();
        end
        n_total++; if (busy_cnt !== 4) $display("FAIL wr_rd_busy_cycles: got %0d want 4", busy_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_resp;
        for (int i = 0; i < 8; i++) do_write(16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
        n_resp = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 8) begin
                en = 1'b1; wr = 1'b0; addr = 16'h0100 + 16'(2 * k);
            end else begin
                en = 1'b0;
            end
            cycle();
            if (k >= 3 && k < 11) begin
                n_total++;
                if (dv !== 1'b1 || dout !== 16'hA000 + 16'(k - 3) || raddr !== 16'h0100 + 16'(2 * (k - 3)))
                    $display("FAIL b2b_resp%0d: got dv=%b data=%h addr=%h want 1 %h %h", k - 3, dv, dout, raddr,
                             16'hA000 + 16'(k - 3), 16'h0100 + 16'(2 * (k - 3)));
                else n_pass++;
            end
            if (dv) n_resp++;
        end
        n_total++; if (n_resp !== 8) $display("FAIL b2b_count: got %0d want 8", n_resp); else n_pass++;
    endtask

    task automatic test_read_then_write();
        logic [15:0] d, ra;
        int lat;
        bit got;
        do_write(16'h0020, 16'h5555);
        en = 1'b1; wr = 1'b0; addr = 16'h0020;
        cycle();
        en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'hAAAA;
        cycle();
        en = 1'b0; wr = 1'b0;
        got = 1'b0; d = '0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (dv) begin got = 1'b1; d = dout; end
            else cycle();
        end
        n_total++; if (!got || d !== 16'h5555) $display("FAIL rd_then_wr_old: got valid=%b data=%h want 1 5555", got, d); else n_pass++;
        cycle();
        do_read(16'h0020, d, ra, lat);
        n_total++; if (d !== 16'hAAAA) $display("FAIL rd_then_wr_new: got %h want aaaa", d); else n_pass++;
    endtask

    task automatic test_odd_and_wrap();
        logic [15:0] d, ra;
        int lat;
        do_write(16'h0030, 16'hBEEF);
        do_read(16'h0031, d, ra, lat);
        n_total++; if (d !== 16'hBEEF) $display("FAIL odd_data: got %h want beef", d); else n_pass++;
        n_total++; if (ra !== 16'h0030) $display("FAIL odd_resp_addr: got %h want 0030", ra); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL odd_latency: got %0d want 3", lat); else n_pass++;
        do_write(16'h0000, 16'h1111);
        do_write(16'hFFFE, 16'h7777);
        do_read(16'hFFFF, d, ra, lat);
        n_total++; if (d !== 16'h7777 || ra !== 16'hFFFE) $display("FAIL wrap_top: got %h@%h want 7777@fffe", d, ra); else n_pass++;
        do_read(16'h0000, d, ra, lat);
        n_total++; if (d !== 16'h1111) $display("FAIL wrap_word0: got %h want 1111", d); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] d, ra;
        int lat, n_dv;
        cycle();
        n_dv = 0;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; wr = 1'b0; addr = 16'h0010 + 16'(16 * i);
            cycle();
            if (dv) n_dv++;
        end
        en = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_total++; if ({dv, dout, raddr} !== 33'h0) $display("FAIL rst_mid_outputs: got dv=%b data=%h addr=%h want 0", dv, dout, raddr); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (dv) n_dv++;
        end
        n_total++; if (n_dv !== 0) $display("FAIL rst_mid_no_valid: got %0d responses want 0", n_dv); else n_pass++;
        do_read(16'h0010, d, ra, lat);
        n_total++; if (d !== 16'h1234) $display("FAIL rst_mid_mem_kept: got %h want 1234", d); else n_pass++;
        cycle();
        rst = 1'b1; en = 1'b1; wr = 1'b1; addr = 16'h0010; din = 16'hDEAD;
        cycle();
        rst = 1'b0; en = 1'b0; wr = 1'b0;
        do_read(16'h0010, d, ra, lat);
        n_total++; if (d !== 16'h1234) $display("FAIL rst_write_dropped: got %h want 1234", d); else n_pass++;
    endtask

    task automatic test_latency1();
        for (int i = 0; i < 5; i++) begin
            en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0200 + 16'(2 * i); din1 = 16'hC000 + 16'(i);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            en1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0200 + 16'(2 * i);
            cycle();
            n_total++;
            if (dv1 !== 1'b1 || dout1 !== 16'hC000 + 16'(i) || raddr1 !== 16'h0200 + 16'(2 * i))
                $display("FAIL lat1_rd%0d: got dv=%b data=%h addr=%h want 1 %h %h", i, dv1, dout1, raddr1,
                         16'hC000 + 16'(i), 16'h0200 + 16'(2 * i));
            else n_pass++;
        end
        en1 = 1'b0;
        cycle();
        n_total++; if ({dv1, busy1, dout1} !== 18'h0) $display("FAIL lat1_idle: got dv=%b busy=%b data=%h want 0", dv1, busy1, dout1); else n_pass++;
        rst1 = 1'b1; en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0200; din1 = 16'hDEAD;
        cycle();
        rst1 = 1'b0; wr1 = 1'b0;
        cycle();
        en1 = 1'b0;
        n_total++; if (dv1 !== 1'b1 || dout1 !== 16'hC000) $display("FAIL lat1_rst_write_dropped: got dv=%b data=%h want 1 c000", dv1, dout1); else n_pass++;
    endtask

    initial begin
        en = 1'b0; wr = 1'b0; addr = '0; din = '0; rst = 1'b0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0; rst1 = 1'b0;
        test_reset();
        test_write_read_latency();
        test_back_to_back();
        test_read_then_write();
        test_odd_and_wrap();
        test_reset_mid_burst();
        test_latency1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
